// File: rtl/regfile_cmd_master_pkg.sv
// ============================================================================
// Module  : regfile_cmd_master_pkg
// Purpose : Shared opcodes, FSM states and widths for the regfile sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_cmd_master_pkg;

  localparam int c_DataWidth = 32;
  localparam int c_AddrWidth = 5;
  localparam int c_NumRegs   = 32;
  localparam int c_OpWidth   = 3;

  localparam logic [c_OpWidth-1:0] OP_NOP     = 3'd0;
  localparam logic [c_OpWidth-1:0] OP_READ    = 3'd1;
  localparam logic [c_OpWidth-1:0] OP_WRITE   = 3'd2;
  localparam logic [c_OpWidth-1:0] OP_COPY    = 3'd3;
  localparam logic [c_OpWidth-1:0] OP_SWAP    = 3'd4;
  localparam logic [c_OpWidth-1:0] OP_ADDI    = 3'd5;
  localparam logic [c_OpWidth-1:0] OP_CLEAR   = 3'd6;
  localparam logic [c_OpWidth-1:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SWAP2 = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Opcodes that pass through the single EXEC cycle.
  function automatic logic isExecOp(input logic [c_OpWidth-1:0] op);
    return (op >= OP_READ) && (op <= OP_ADDI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_cmd_master_if.sv
// ============================================================================
// Module  : regfile_cmd_master_if
// Purpose : Command/response streams plus register-file port bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_cmd_master_if
  import regfile_cmd_master_pkg::*;
#(
  parameter int DataWidth = c_DataWidth,
  parameter int AddrWidth = c_AddrWidth
);

  logic                 CmdValid;
  logic                 CmdReady;
  logic [c_OpWidth-1:0] CmdOp;
  logic [AddrWidth-1:0] CmdRegA;
  logic [AddrWidth-1:0] CmdRegB;
  logic [DataWidth-1:0] CmdData;

  logic                 RspValid;
  logic                 RspReady;
  logic [DataWidth-1:0] RspData1;
  logic [DataWidth-1:0] RspData2;
  logic                 Error;
  logic                 Busy;

  logic [AddrWidth-1:0] ReadRegister1;
  logic [AddrWidth-1:0] ReadRegister2;
  logic [DataWidth-1:0] ReadData1;
  logic [DataWidth-1:0] ReadData2;
  logic [AddrWidth-1:0] WriteRegister;
  logic [DataWidth-1:0] WriteData;
  logic                 RegWrite;

  modport master (
    input  CmdValid, CmdOp, CmdRegA, CmdRegB, CmdData,
    input  RspReady, ReadData1, ReadData2,
    output CmdReady, RspValid, RspData1, RspData2, Error, Busy,
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite
  );

  modport slave (
    output CmdValid, CmdOp, CmdRegA, CmdRegB, CmdData,
    output RspReady, ReadData1, ReadData2,
    input  CmdReady, RspValid, RspData1, RspData2, Error, Busy,
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite
  );

endinterface

`default_nettype wire

// File: rtl/regfile_cmd_master.sv
// ============================================================================
// Module  : regfile_cmd_master
// Purpose : Sequences debug/preload commands onto a 2R1W register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_cmd_master
  import regfile_cmd_master_pkg::*;
#(
  parameter int DataWidth = c_DataWidth,
  parameter int AddrWidth = c_AddrWidth,
  parameter int NumRegs   = c_NumRegs
) (
  input  wire logic            Clk,
  input  wire logic            Reset_n,
  regfile_cmd_master_if.master bus
);

  state_t               r_state;
  logic [c_OpWidth-1:0] r_op;
  logic [DataWidth-1:0] r_data;
  logic [DataWidth-1:0] r_temp;
  logic [AddrWidth-1:0] r_clearCnt;

  logic                 r_cmdReady;
  logic                 r_rspValid;
  logic [DataWidth-1:0] r_rspData1;
  logic [DataWidth-1:0] r_rspData2;
  logic                 r_error;
  logic                 r_busy;
  logic [AddrWidth-1:0] r_readReg1;
  logic [AddrWidth-1:0] r_readReg2;
  logic [AddrWidth-1:0] r_writeReg;
  logic                 r_regWrite;

  logic                 w_accept;
  logic [DataWidth-1:0] w_writeData;

  assign w_accept = bus.CmdValid && r_cmdReady;

  // Write data depends on the async read ports during EXEC, so it cannot be
  // registered without adding a cycle; it is zero outside write states.
  always_comb begin
    w_writeData = '0;
    case (r_state)
      ST_EXEC: begin
        case (r_op)
          OP_WRITE: w_writeData = r_data;
          OP_COPY:  w_writeData = bus.ReadData2;
          OP_SWAP:  w_writeData = bus.ReadData2;
          OP_ADDI:  w_writeData = bus.ReadData1 + r_data;
          default:  w_writeData = '0;
        endcase
      end
      ST_SWAP2: w_writeData = r_temp;
      default:  w_writeData = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_data     <= '0;
      r_temp     <= '0;
      r_clearCnt <= AddrWidth'(1);
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspData1 <= '0;
      r_rspData2 <= '0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_readReg1 <= '0;
      r_readReg2 <= '0;
      r_writeReg <= '0;
      r_regWrite <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.CmdOp;
            r_data <= bus.CmdData;
            if (isExecOp(bus.CmdOp)) begin
              r_state    <= ST_EXEC;
              r_cmdReady <= 1'b0;
              r_busy     <= 1'b1;
              r_readReg1 <= bus.CmdRegA;
              r_readReg2 <= bus.CmdRegB;
              r_writeReg <= bus.CmdRegA;
              r_regWrite <= (bus.CmdOp != OP_READ);
            end else if (bus.CmdOp == OP_CLEAR) begin
              r_state    <= ST_CLEAR;
              r_cmdReady <= 1'b0;
              r_busy     <= 1'b1;
              r_writeReg <= r_clearCnt;
              r_regWrite <= 1'b1;
            end else if (bus.CmdOp == OP_ILLEGAL) begin
              r_error <= 1'b1;
            end
          end
        end

        ST_EXEC: begin
          if (r_op == OP_SWAP) begin
            // Pre-write value of A; the write to A lands on this same edge.
            r_temp     <= bus.ReadData1;
            r_writeReg <= r_readReg2;
            r_state    <= ST_SWAP2;
          end else if (r_op == OP_READ) begin
            r_rspData1 <= bus.ReadData1;
            r_rspData2 <= bus.ReadData2;
            r_rspValid <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_regWrite <= 1'b0;
            r_cmdReady <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_SWAP2: begin
          r_regWrite <= 1'b0;
          r_cmdReady <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        ST_CLEAR: begin
          if (r_clearCnt == AddrWidth'(NumRegs - 1)) begin
            r_regWrite <= 1'b0;
            r_cmdReady <= 1'b1;
            r_busy     <= 1'b0;
            r_clearCnt <= AddrWidth'(1);
            r_state    <= ST_IDLE;
          end else begin
            r_clearCnt <= r_clearCnt + AddrWidth'(1);
            r_writeReg <= r_clearCnt + AddrWidth'(1);
          end
        end

        ST_RESP: begin
          if (bus.RspReady) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_regWrite <= 1'b0;
          r_rspValid <= 1'b0;
          r_cmdReady <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CmdReady      = r_cmdReady;
  assign bus.RspValid      = r_rspValid;
  assign bus.RspData1      = r_rspData1;
  assign bus.RspData2      = r_rspData2;
  assign bus.Error         = r_error;
  assign bus.Busy          = r_busy;
  assign bus.ReadRegister1 = r_readReg1;
  assign bus.ReadRegister2 = r_readReg2;
  assign bus.WriteRegister = r_writeReg;
  assign bus.WriteData     = w_writeData;
  assign bus.RegWrite      = r_regWrite;

endmodule

`default_nettype wire

// File: tb/tb_regfile_cmd_master.sv
// ============================================================================
// Module  : tb_regfile_cmd_master
// Purpose : Scoreboarded bench with a behavioural 32x32 register file responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_cmd_master;
  import regfile_cmd_master_pkg::*;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    string       name;
  } exp_t;

  exp_t expQ[$];

  regfile_cmd_master_if #(.DataWidth(32), .AddrWidth(5)) bus ();

  regfile_cmd_master #(.DataWidth(32), .AddrWidth(5), .NumRegs(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Responder: async read, sync write, register 0 hard-wired to zero.
  logic [31:0] rf [32];
  assign bus.ReadData1 = (bus.ReadRegister1 == 5'd0) ? 32'd0 : rf[bus.ReadRegister1];
  assign bus.ReadData2 = (bus.ReadRegister2 == 5'd0) ? 32'd0 : rf[bus.ReadRegister2];
  always @(posedge Clk) begin
    if (bus.RegWrite && bus.WriteRegister != 5'd0)
      rf[bus.WriteRegister] <= bus.WriteData;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation.
  always @(negedge Clk) begin
    if (Reset_n && bus.RspValid && bus.RspReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h/%0h expected=none", bus.RspData1, bus.RspData2);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check({e.name, ".d1"}, bus.RspData1, e.d1);
        check({e.name, ".d2"}, bus.RspData2, e.d2);
      end
    end
  end

  // Returns just after the accepting edge.
  task automatic sendCmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] d);
    int n;
    n = 0;
    @(negedge Clk);
    while (!bus.CmdReady && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!bus.CmdReady) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout actual=CmdReady0 expected=CmdReady1 op=%0d", op);
    end
    bus.CmdOp    = op;
    bus.CmdRegA  = a;
    bus.CmdRegB  = b;
    bus.CmdData  = d;
    bus.CmdValid = 1'b1;
    @(posedge Clk);
    #1;
    bus.CmdValid = 1'b0;
    bus.CmdData  = 32'hA5A5A5A5;
  endtask

  task automatic readCmd(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] e1, input logic [31:0] e2, input string name);
    exp_t e;
    e.d1 = e1;
    e.d2 = e2;
    e.name = name;
    expQ.push_back(e);
    sendCmd(OP_READ, a, b, 32'd0);
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 1; i < 32; i++)
      sendCmd(OP_WRITE, 5'(i), 5'd0, base + 32'(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1'b0;
    bus.CmdValid = 1'b0;
    bus.CmdOp    = OP_NOP;
    bus.CmdRegA  = 5'd0;
    bus.CmdRegB  = 5'd0;
    bus.CmdData  = 32'd0;
    bus.RspReady = 1'b1;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_cmdready", {31'd0, bus.CmdReady}, 32'd1);
    check("rst_status", {28'd0, bus.RspValid, bus.Error, bus.Busy, bus.RegWrite}, 32'd0);
    check("rst_addrs", {17'd0, bus.ReadRegister1, bus.ReadRegister2, bus.WriteRegister}, 32'd0);
    check("rst_wdata", bus.WriteData, 32'd0);
    check("rst_rspdata", bus.RspData1 | bus.RspData2, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Write then read back with response latency check.
    sendCmd(OP_WRITE, 5'd5, 5'd0, 32'hDEADBEEF);
    readCmd(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, "read_r5_r0");
    @(negedge Clk);
    check("read_exec_norsp", {31'd0, bus.RspValid}, 32'd0);
    check("read_exec_nowrite", {31'd0, bus.RegWrite}, 32'd0);
    @(negedge Clk);
    check("read_rsp_latency", {31'd0, bus.RspValid}, 32'd1);

    // Swap with write-port trace.
    sendCmd(OP_WRITE, 5'd3, 5'd0, 32'h11);
    sendCmd(OP_WRITE, 5'd7, 5'd0, 32'h22);
    sendCmd(OP_SWAP, 5'd3, 5'd7, 32'd0);
    @(negedge Clk);
    check("swap_w1", {bus.RegWrite, 26'd0, bus.WriteRegister}, {1'b1, 26'd0, 5'd3});
    check("swap_w1_data", bus.WriteData, 32'h22);
    @(negedge Clk);
    check("swap_w2", {bus.RegWrite, 26'd0, bus.WriteRegister}, {1'b1, 26'd0, 5'd7});
    check("swap_w2_data", bus.WriteData, 32'h11);
    @(negedge Clk);
    check("swap_done", {30'd0, bus.RegWrite, bus.CmdReady}, 32'd1);
    readCmd(5'd3, 5'd7, 32'h22, 32'h11, "read_swapped");

    // ADDI wraps modulo 2^32; COPY moves the result.
    sendCmd(OP_WRITE, 5'd4, 5'd0, 32'hFFFFFFFF);
    sendCmd(OP_ADDI, 5'd4, 5'd0, 32'd2);
    readCmd(5'd4, 5'd0, 32'h1, 32'd0, "read_addi_wrap");
    sendCmd(OP_COPY, 5'd9, 5'd4, 32'd0);
    readCmd(5'd9, 5'd4, 32'h1, 32'h1, "read_copy");

    // Swap corner cases: B=0 zeroes A; A=B is a no-op.
    sendCmd(OP_SWAP, 5'd9, 5'd0, 32'd0);
    readCmd(5'd9, 5'd0, 32'd0, 32'd0, "read_swap_b0");
    sendCmd(OP_SWAP, 5'd3, 5'd3, 32'd0);
    readCmd(5'd3, 5'd7, 32'h22, 32'h11, "read_swap_same");

    // Illegal opcode.
    sendCmd(OP_ILLEGAL, 5'd1, 5'd2, 32'h55);
    check("illegal_error", {29'd0, bus.Error, bus.RegWrite, bus.CmdReady}, 32'b101);
    @(posedge Clk);
    #1;
    check("illegal_pulse_end", {30'd0, bus.Error, bus.Busy}, 32'd0);

    // Response back-pressure.
    sendCmd(OP_WRITE, 5'd12, 5'd0, 32'hCAFE0012);
    bus.RspReady = 1'b0;
    readCmd(5'd12, 5'd5, 32'hCAFE0012, 32'hDEADBEEF, "read_backpressure");
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("hold_valid_ready", {30'd0, bus.RspValid, bus.CmdReady}, 32'b10);
      check("hold_d1", bus.RspData1, 32'hCAFE0012);
      check("hold_d2", bus.RspData2, 32'hDEADBEEF);
    end
    @(posedge Clk);
    #1;
    bus.RspReady = 1'b1;
    @(posedge Clk);
    #1;
    check("rsp_drop", {30'd0, bus.RspValid, bus.CmdReady}, 32'b01);

    // Full clear sweep.
    preload(32'h100);
    sendCmd(OP_CLEAR, 5'd0, 5'd0, 32'd0);
    for (int i = 1; i < 32; i++) begin
      @(negedge Clk);
      check("clear_sweep", {bus.RegWrite, bus.CmdReady, 25'd0, bus.WriteRegister},
            {1'b1, 1'b0, 25'd0, 5'(i)});
      check("clear_wdata", bus.WriteData, 32'd0);
    end
    @(negedge Clk);
    check("clear_done", {30'd0, bus.RegWrite, bus.CmdReady}, 32'd1);
    readCmd(5'd1, 5'd31, 32'd0, 32'd0, "read_cleared_1_31");
    readCmd(5'd15, 5'd16, 32'd0, 32'd0, "read_cleared_15_16");

    // Reset in the middle of a clear.
    preload(32'h200);
    sendCmd(OP_CLEAR, 5'd0, 5'd0, 32'd0);
    repeat (10) @(posedge Clk);
    #2;
    check("clear_pre_reset", {bus.RegWrite, 26'd0, bus.WriteRegister}, {1'b1, 26'd0, 5'd11});
    Reset_n = 1'b0;
    #1;
    check("reset_async", {29'd0, bus.RegWrite, bus.Busy, bus.CmdReady}, 32'b001);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("post_reset_ready", {31'd0, bus.CmdReady}, 32'd1);
    readCmd(5'd1, 5'd10, 32'd0, 32'd0, "read_abort_1_10");
    readCmd(5'd11, 5'd31, 32'h20B, 32'h21F, "read_abort_11_31");
    readCmd(5'd5, 5'd20, 32'd0, 32'h214, "read_abort_5_20");

    repeat (6) @(posedge Clk);
    #1;
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
